// File: rtl/test_pattern_sequencer.sv
// Test pattern sequencer: picks pattern_sel from DIP, auto-cycle or button.
// New selections commit only on the first blanking line so frames never tear.
module test_pattern_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_FRAMES     = 120,
  parameter int V_ACTIVE        = 480
) (
  input  logic        clk_pixel,
  input  logic        rst,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [1:0]  mode,
  input  logic [2:0]  dip_pattern,
  input  logic        btn_next,
  output logic [2:0]  pattern_sel,
  output logic        sel_changed,
  output logic [15:0] frame_count,
  output logic        btn_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_FRAMES) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic [9:0] TICK_Y = 10'(V_ACTIVE);

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_STEP   = 2'b10,
    MODE_FREEZE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_HELD,
    DB_RELEASE_WAIT
  } db_state_e;

  logic            r_sync1;
  logic            r_sync2;
  logic            w_btn_s;

  db_state_e       r_db_state;
  db_state_e       w_db_state_next;
  logic [DW-1:0]   r_db_cnt;
  logic [DW-1:0]   w_db_cnt_next;
  logic            w_btn_pulse;

  mode_e           w_mode;
  mode_e           r_mode_q;
  logic            w_mode_chg;
  logic            w_tick;
  logic            w_step_go;

  logic [2:0]      r_sel;
  logic [2:0]      w_sel_next;
  logic            r_sel_chg;
  logic [15:0]     r_frame_cnt;
  logic [HW-1:0]   r_hold;
  logic [HW-1:0]   w_hold_next;
  logic            r_step_req;
  logic            w_step_req_next;

  assign w_btn_s = r_sync2;
  assign w_mode  = mode_e'(mode);

  // Two-flop synchronizer for the raw push button.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_next;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce state and stability counter.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      r_db_state <= DB_IDLE;
      r_db_cnt   <= '0;
    end else begin
      r_db_state <= w_db_state_next;
      r_db_cnt   <= w_db_cnt_next;
    end
  end

  // Debounce transitions; the press strobe fires on the PRESS_WAIT->HELD step.
  always_comb begin
    w_db_state_next = r_db_state;
    w_db_cnt_next   = r_db_cnt;
    w_btn_pulse     = 1'b0;
    unique case (r_db_state)
      DB_IDLE: begin
        if (w_btn_s) begin
          w_db_state_next = DB_PRESS_WAIT;
          w_db_cnt_next   = '0;
        end
      end
      DB_PRESS_WAIT: begin
        if (!w_btn_s) begin
          w_db_state_next = DB_IDLE;
        end else if (r_db_cnt == DB_LAST) begin
          w_db_state_next = DB_HELD;
          w_btn_pulse     = 1'b1;
        end else begin
          w_db_cnt_next = r_db_cnt + DW'(1);
        end
      end
      DB_HELD: begin
        if (!w_btn_s) begin
          w_db_state_next = DB_RELEASE_WAIT;
          w_db_cnt_next   = '0;
        end
      end
      DB_RELEASE_WAIT: begin
        if (w_btn_s) begin
          w_db_state_next = DB_HELD;
        end else if (r_db_cnt == DB_LAST) begin
          w_db_state_next = DB_IDLE;
        end else begin
          w_db_cnt_next = r_db_cnt + DW'(1);
        end
      end
      default: begin
        w_db_state_next = DB_IDLE;
        w_db_cnt_next   = '0;
      end
    endcase
  end

  // Frame tick and mode-change decode.
  always_comb begin
    w_tick     = (pixel_y == TICK_Y) && (pixel_x == 10'd0);
    w_mode_chg = (w_mode != r_mode_q);
    w_step_go  = r_step_req | w_btn_pulse;
  end

  // Next pattern, decided only on the tick cycle.
  always_comb begin
    w_sel_next = r_sel;
    if (w_tick) begin
      unique case (w_mode)
        MODE_MANUAL: w_sel_next = dip_pattern;
        MODE_AUTO: begin
          if (r_hold == HOLD_LAST) w_sel_next = r_sel + 3'd1;
        end
        MODE_STEP: begin
          if (w_step_go) w_sel_next = r_sel + 3'd1;
        end
        MODE_FREEZE: w_sel_next = r_sel;
        default: w_sel_next = r_sel;
      endcase
    end
  end

  // Frame hold counter for AUTO; a mode change restarts it.
  always_comb begin
    w_hold_next = r_hold;
    if (w_mode_chg) begin
      w_hold_next = '0;
    end else if (w_tick && (w_mode == MODE_AUTO)) begin
      if (r_hold == HOLD_LAST) w_hold_next = '0;
      else w_hold_next = r_hold + HW'(1);
    end
  end

  // Pending step request: presses coalesce until the next tick.
  always_comb begin
    w_step_req_next = r_step_req;
    if (w_mode_chg || (w_mode != MODE_STEP)) begin
      w_step_req_next = 1'b0;
    end else if (w_tick && w_step_go) begin
      w_step_req_next = 1'b0;
    end else if (w_btn_pulse) begin
      w_step_req_next = 1'b1;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      r_sel       <= 3'd0;
      r_sel_chg   <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_hold      <= '0;
      r_step_req  <= 1'b0;
      r_mode_q    <= MODE_MANUAL;
    end else begin
      r_sel       <= w_sel_next;
      r_sel_chg   <= w_tick && (w_sel_next != r_sel);
      r_hold      <= w_hold_next;
      r_step_req  <= w_step_req_next;
      r_mode_q    <= w_mode;
      if (w_tick) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign pattern_sel = r_sel;
  assign sel_changed = r_sel_chg;
  assign frame_count = r_frame_cnt;
  assign btn_pulse   = w_btn_pulse;

endmodule

// File: tb/tb_test_pattern_sequencer.sv
// Bench for test_pattern_sequencer: vector table, directed corner
// sequences and random traffic against a run-length reference model.
module tb_test_pattern_sequencer;

  localparam int DB = 4;
  localparam int HF = 3;
  localparam int VA = 480;
  localparam int XM = 15;
  localparam int Y0 = 477;
  localparam int Y1 = 482;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  px;
  logic [9:0]  py;
  logic [1:0]  mode;
  logic [2:0]  dip;
  logic        btn;
  logic [2:0]  pattern_sel;
  logic        sel_changed;
  logic [15:0] frame_count;
  logic        btn_pulse;

  test_pattern_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_FRAMES(HF),
    .V_ACTIVE(VA)
  ) dut (
    .clk_pixel(clk),
    .rst(rst),
    .pixel_x(px),
    .pixel_y(py),
    .mode(mode),
    .dip_pattern(dip),
    .btn_next(btn),
    .pattern_sel(pattern_sel),
    .sel_changed(sel_changed),
    .frame_count(frame_count),
    .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit cmp_en = 1'b0;

  // reference model state
  bit m_s1, m_s2, m_armed, m_req, m_chg;
  int m_hr, m_lr, m_sel, m_hold, m_mq, m_fc;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] dip;
    int esel;
    int echg;
    int efc;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_armed = 1; m_req = 0; m_chg = 0;
    m_hr = 0; m_lr = 0; m_sel = 0; m_hold = 0; m_mq = 0; m_fc = 0;
  endtask

  // A press is recognised once the synced button has been high DB+1
  // cycles in a row while armed; it re-arms after DB+1 low cycles.
  function automatic bit m_pulse();
    return m_armed && m_s2 && (m_hr + 1 == DB + 1);
  endfunction

  task automatic model_step();
    bit p, tk, mc;
    int old, md;
    if (rst) begin
      model_reset();
      return;
    end
    p = m_pulse();
    if (!m_armed && !m_s2 && (m_lr + 1 == DB + 1)) m_armed = 1;
    if (p) m_armed = 0;
    m_hr = m_s2 ? ((m_hr < 1000) ? m_hr + 1 : m_hr) : 0;
    m_lr = m_s2 ? 0 : ((m_lr < 1000) ? m_lr + 1 : m_lr);
    m_s2 = m_s1;
    m_s1 = btn;
    md = int'(mode);
    tk = (px == 10'd0) && (int'(py) == VA);
    mc = (md != m_mq);
    old = m_sel;
    if (tk) begin
      if (md == 0) m_sel = int'(dip);
      else if (md == 1 && m_hold == HF - 1) m_sel = (m_sel + 1) % 8;
      else if (md == 2 && (m_req || p)) m_sel = (m_sel + 1) % 8;
    end
    if (mc) m_hold = 0;
    else if (tk && md == 1) m_hold = (m_hold + 1) % HF;
    if (md != 2 || mc) m_req = 0;
    else if (tk && (m_req || p)) m_req = 0;
    else if (p) m_req = 1;
    m_chg = tk && (m_sel != old);
    if (tk) m_fc = (m_fc + 1) % 65536;
    m_mq = md;
  endtask

  task automatic clk1();
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (btn_pulse) pulses++;
    if (cmp_en) begin
      chk("rnd_sel", int'(pattern_sel), m_sel);
      chk("rnd_chg", int'(sel_changed), int'(m_chg));
      chk("rnd_fc", int'(frame_count), m_fc);
      chk("rnd_pulse", int'(btn_pulse), int'(m_pulse()));
    end
  endtask

  task automatic adv();
    if (int'(px) == XM) begin
      px = 10'd0;
      py = (int'(py) == Y1) ? 10'(Y0) : py + 10'd1;
    end else begin
      px = px + 10'd1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      clk1();
      adv();
    end
  endtask

  // Step until the tick position, then clock the tick itself.
  task automatic to_tick();
    for (int i = 0; i < 200; i++) begin
      if (px == 10'd0 && int'(py) == VA) break;
      run(1);
    end
    run(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    px = 10'd0;
    py = 10'(Y0);
    pulses = 0;
  endtask

  initial begin
    rst = 1'b1;
    px = 10'd0;
    py = 10'(Y0);
    mode = 2'd0;
    dip = 3'd0;
    btn = 1'b0;
    model_reset();

    tbl[0] = '{10'd0,   10'd479, 3'd3, 0, 0, 0};
    tbl[1] = '{10'd1,   10'd480, 3'd3, 0, 0, 0};
    tbl[2] = '{10'd0,   10'd480, 3'd3, 3, 1, 1};
    tbl[3] = '{10'd0,   10'd480, 3'd3, 3, 0, 2};
    tbl[4] = '{10'd0,   10'd481, 3'd6, 3, 0, 2};
    tbl[5] = '{10'd0,   10'd992, 3'd6, 3, 0, 2};
    tbl[6] = '{10'd0,   10'd480, 3'd6, 6, 1, 3};
    tbl[7] = '{10'd15,  10'd480, 3'd1, 6, 0, 3};
    tbl[8] = '{10'd0,   10'd480, 3'd1, 1, 1, 4};

    repeat (2) @(negedge clk);
    chk("rst_sel", int'(pattern_sel), 0);
    chk("rst_chg", int'(sel_changed), 0);
    chk("rst_fc", int'(frame_count), 0);
    chk("rst_pulse", int'(btn_pulse), 0);
    rst = 1'b0;

    // tick decode and MANUAL commit, one vector per cycle
    for (int i = 0; i < 9; i++) begin
      px = tbl[i].x;
      py = tbl[i].y;
      dip = tbl[i].dip;
      clk1();
      chk($sformatf("vec%0d_sel", i), int'(pattern_sel), tbl[i].esel);
      chk($sformatf("vec%0d_chg", i), int'(sel_changed), tbl[i].echg);
      chk($sformatf("vec%0d_fc", i), int'(frame_count), tbl[i].efc);
    end

    // MANUAL: mid-frame DIP change waits for the tick
    mode = 2'd0;
    dip = 3'd0;
    do_reset();
    run(5);
    dip = 3'd5;
    run(3);
    chk("man_sel_pre", int'(pattern_sel), 0);
    to_tick();
    chk("man_sel_tick", int'(pattern_sel), 5);
    chk("man_chg_tick", int'(sel_changed), 1);
    run(1);
    chk("man_chg_after", int'(sel_changed), 0);
    to_tick();
    chk("man_sel_same", int'(pattern_sel), 5);
    chk("man_chg_same", int'(sel_changed), 0);
    chk("man_fc", int'(frame_count), 2);

    // AUTO: advance every HF ticks with 7->0 wrap
    mode = 2'd1;
    do_reset();
    for (int t = 1; t <= 24; t++) begin
      to_tick();
      chk($sformatf("auto_sel_t%0d", t), int'(pattern_sel), (t / HF) % 8);
    end
    chk("auto_fc", int'(frame_count), 24);

    // STEP: bouncy press gives one pulse, one advance
    mode = 2'd2;
    do_reset();
    begin
      bit seq[10] = '{1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
      for (int i = 0; i < 10; i++) begin
        btn = seq[i];
        run(1);
      end
    end
    btn = 1'b0;
    chk("step_bounce_pulses", pulses, 1);
    chk("step_sel_pre", int'(pattern_sel), 0);
    to_tick();
    chk("step_sel_tick", int'(pattern_sel), 1);
    chk("step_chg_tick", int'(sel_changed), 1);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      btn = 1'b1;
      run(6);
      btn = 1'b0;
      run(6);
    end
    chk("step_three_pulses", pulses, 3);
    chk("step_sel_wait", int'(pattern_sel), 1);
    to_tick();
    chk("step_sel_single", int'(pattern_sel), 2);
    to_tick();
    chk("step_sel_idle", int'(pattern_sel), 2);

    // STEP: pulse lands on the tick cycle, button then held
    for (int i = 0; i < 200; i++) begin
      if (int'(py) == VA - 1 && int'(px) == XM - 5) break;
      run(1);
    end
    pulses = 0;
    btn = 1'b1;
    run(6);
    chk("coin_pulse_on_tick", int'(btn_pulse), 1);
    run(1);
    chk("coin_sel", int'(pattern_sel), 3);
    chk("coin_chg", int'(sel_changed), 1);
    for (int t = 0; t < 3; t++) begin
      to_tick();
      chk($sformatf("held_sel_t%0d", t), int'(pattern_sel), 3);
    end
    chk("held_pulses", pulses, 1);
    btn = 1'b0;
    run(12);

    // FREEZE in the middle of an AUTO hold
    mode = 2'd1;
    do_reset();
    repeat (5) to_tick();
    chk("frz_auto_sel", int'(pattern_sel), 1);
    mode = 2'd3;
    for (int t = 0; t < 5; t++) begin
      to_tick();
      chk($sformatf("frz_sel_t%0d", t), int'(pattern_sel), 1);
    end
    mode = 2'd1;
    to_tick();
    chk("frz_back_t1", int'(pattern_sel), 1);
    to_tick();
    chk("frz_back_t2", int'(pattern_sel), 1);
    to_tick();
    chk("frz_back_t3", int'(pattern_sel), 2);

    // async reset during PRESS_WAIT
    mode = 2'd0;
    dip = 3'd6;
    do_reset();
    to_tick();
    chk("ar_sel_pre", int'(pattern_sel), 6);
    btn = 1'b1;
    run(4);
    #1 rst = 1'b1;
    #1;
    chk("ar_sel", int'(pattern_sel), 0);
    chk("ar_chg", int'(sel_changed), 0);
    chk("ar_fc", int'(frame_count), 0);
    chk("ar_pulse", int'(btn_pulse), 0);
    btn = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    px = 10'd0;
    py = 10'(Y0);
    pulses = 0;
    run(20);
    chk("ar_no_pulse", pulses, 0);
    chk("ar_sel_post", int'(pattern_sel), 0);

    // random traffic against the model
    btn = 1'b0;
    do_reset();
    cmp_en = 1'b1;
    for (int s = 0; s < 120; s++) begin
      int len;
      if (s == 60) do_reset();
      mode = 2'($urandom_range(0, 3));
      dip = 3'($urandom);
      len = int'($urandom_range(5, 60));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) btn = ~btn;
        run(1);
      end
    end
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_pattern_sequencer.md
Name: test_pattern_sequencer

Overview:
Controller that drives pattern_sel of the test pattern generator. It selects between manual DIP selection, timed auto-cycling and button stepping. Pattern changes are committed only during vertical blanking, so a frame never tears. Sits between the board switches/buttons, the video timing generator and the pattern generator, all in the clk_pixel domain.

Parameters:
DEBOUNCE_CYCLES, 250000, clk_pixel cycles the button must stay stable (10 ms at 25 MHz); counter width is $clog2(DEBOUNCE_CYCLES)+1.
HOLD_FRAMES, 120, frames each pattern is shown in AUTO mode; must be >= 1.
V_ACTIVE, 480, first blanking line index; used to form frame_tick.

Ports:
clk_pixel  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
pixel_x  in  10  horizontal counter from video timing gen
pixel_y  in  10  vertical counter from video timing gen
mode  in  2  00=MANUAL, 01=AUTO, 10=STEP, 11=FREEZE
dip_pattern  in  3  manual pattern number
btn_next  in  1  raw asynchronous push button, active high
pattern_sel  out  3  registered pattern select to the generator
sel_changed  out  1  one-cycle pulse when pattern_sel changes value
frame_count  out  16  frames since reset, wraps at 65535->0
btn_pulse  out  1  one-cycle debounced press strobe (also used internally)

Behaviour:
- Reset (async assert): pattern_sel=0, sel_changed=0, frame_count=0, btn_pulse=0, hold counter=0, step_req=0, debounce FSM=IDLE, debounce counter=0, sync FFs=0, mode_q=00. All state is released synchronously on clk_pixel.
- frame_tick = (pixel_y==V_ACTIVE) && (pixel_x==0). This is combinational and true for exactly one cycle per frame.
- frame_count increments on each frame_tick.
- pattern_sel is updated only on the clk edge where frame_tick=1. The new value is visible the next cycle, within blanking. Latency from the decision to the generator input is 1 cycle after the tick.
- MANUAL: at the tick, pattern_sel <= dip_pattern. DIP changes between ticks have no effect until the next tick.
- AUTO:
  - At each tick, if hold counter == HOLD_FRAMES-1, then pattern_sel <= pattern_sel+1 (3-bit wrap, 7->0) and the counter clears.
  - Otherwise the counter increments and pattern_sel holds.
- STEP:
  - btn_pulse sets step_req.
  - At a tick where (step_req | btn_pulse)=1, pattern_sel <= pattern_sel+1 (wraps) and step_req clears.
  - Multiple presses between ticks give a single advance.
  - A press on the tick cycle itself is consumed by that tick.
- FREEZE: pattern_sel holds; the hold counter holds.
- Mode change: mode_q registers mode. When mode != mode_q, the hold counter clears and step_req clears. The new mode takes effect at the next tick.
- step_req clears whenever mode != STEP.
- sel_changed=1 for the one cycle after the tick in which pattern_sel took a different value. Rewriting the same value does not pulse it.
- btn_next passes through a 2-FF synchronizer to give btn_s.
- Debounce FSM:
  - IDLE: btn_s=1 -> PRESS_WAIT, counter=0.
  - PRESS_WAIT:
    - btn_s=0 -> IDLE.
    - Otherwise the counter increments.
    - When counter==DEBOUNCE_CYCLES-1 -> HELD, and btn_pulse=1 for exactly that transition cycle.
  - HELD: btn_s=0 -> RELEASE_WAIT, counter=0.
  - RELEASE_WAIT:
    - btn_s=1 -> HELD (bounce, no new pulse).
    - Otherwise the counter increments.
    - When counter==DEBOUNCE_CYCLES-1 -> IDLE.
  - Holding the button produces one pulse only.
- Reset asserted mid-frame or mid-debounce aborts everything to the reset values. The first post-reset tick behaves as a normal tick.

Test Plan:
(Params: DEBOUNCE_CYCLES=4, HOLD_FRAMES=3, small timing model reaching pixel_y=480.)
- MANUAL, dip_pattern=5 set mid-frame -> pattern_sel stays 0 until the tick, becomes 5 one cycle after the tick, sel_changed pulses once; with dip held at 5, the next tick gives no pulse.
- AUTO from reset -> pattern_sel=0 for ticks 1-2, becomes 1 after tick 3, 2 after tick 6; after 24 ticks it is back to 0 (7->0 wrap); frame_count=24.
- STEP, button pressed 10 cycles with bounce (1,0,1 in the first 3 cycles) -> exactly one btn_pulse; pattern_sel 0->1 at the next tick only. Three clean presses within one frame -> single advance.
- STEP, btn_pulse coincident with frame_tick -> advance at that tick and step_req=0 afterwards; a held button through 3 ticks -> only one advance.
- AUTO with hold counter=2, switch to FREEZE for 5 ticks, then back to AUTO -> pattern_sel unchanged during FREEZE; after returning, the next advance occurs on the 3rd tick.
- Assert rst mid-PRESS_WAIT with pattern_sel=6 -> all outputs are 0 immediately (async); no btn_pulse after release.
